// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V writeback stage: result select, load extract, register-file write port.
// Optional load-response timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_stage #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  instr_valid_in,
    output logic                  instr_ready_out,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  rd_wr_en_in,
    input  logic [1:0]            wb_src_in,
    input  logic [31:0]           alu_result_in,
    input  logic [31:0]           pc_plus4_in,
    input  logic [31:0]           csr_data_in,
    input  logic [2:0]            load_funct3_in,
    input  logic [1:0]            load_addr_lsb_in,
    input  logic                  load_rsp_valid_in,
    input  logic [31:0]           load_rsp_data_in,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic                  wr_en_out,
    output logic [31:0]           rd_out,
    output logic                  retire_out,
    output logic                  load_err_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_t;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    state_t                state;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic                  cap_wr;
    logic [2:0]            cap_funct3;
    logic [1:0]            cap_lsb;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    logic        accept;
    logic        writes_rd;
    logic        load_bad;
    logic [31:0] sel_data;
    logic [31:0] load_data;

    assign accept    = instr_valid_in & instr_ready_out;
    assign writes_rd = rd_wr_en_in & (rd_addr_in != '0);

    always_comb begin
        load_bad = 1'b1;
        case (load_funct3_in)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = load_addr_lsb_in[0];
            3'b010:         load_bad = (load_addr_lsb_in != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (wb_src_in)
            SRC_ALU: sel_data = alu_result_in;
            SRC_PC4: sel_data = pc_plus4_in;
            default: sel_data = csr_data_in;
        endcase
    end

    // Extraction uses the fields captured at accept, not the live mem-stage inputs.
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = load_rsp_data_in[8*cap_lsb +: 8];
        half_v = cap_lsb[1] ? load_rsp_data_in[31:16] : load_rsp_data_in[15:0];
        case (cap_funct3)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_data = {24'd0, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'd0, half_v};
            default: load_data = load_rsp_data_in;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= IDLE;
            instr_ready_out <= 1'b1;
            rd_addr_out     <= '0;
            wr_en_out       <= 1'b0;
            rd_out          <= '0;
            retire_out      <= 1'b0;
            load_err_out    <= 1'b0;
            cap_rd          <= '0;
            cap_wr          <= 1'b0;
            cap_funct3      <= '0;
            cap_lsb         <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            wr_en_out    <= 1'b0;
            retire_out   <= 1'b0;
            load_err_out <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (accept) begin
                        rd_addr_out <= rd_addr_in;
                        if (wb_src_in != SRC_LOAD) begin
                            state           <= WRITE;
                            instr_ready_out <= 1'b1;
                            rd_out          <= sel_data;
                            wr_en_out       <= writes_rd;
                            retire_out      <= 1'b1;
                        end else if (load_bad) begin
                            state           <= WRITE;
                            instr_ready_out <= 1'b1;
                            load_err_out    <= 1'b1;
                            retire_out      <= 1'b1;
                        end else begin
                            state           <= WAIT_LOAD;
                            instr_ready_out <= 1'b0;
                            cap_rd          <= rd_addr_in;
                            cap_wr          <= writes_rd;
                            cap_funct3      <= load_funct3_in;
                            cap_lsb         <= load_addr_lsb_in;
`ifdef WB_LOAD_TIMEOUT_EN
                            wait_cnt        <= '0;
`endif
                        end
                    end else begin
                        state           <= IDLE;
                        instr_ready_out <= 1'b1;
                    end
                end
                WAIT_LOAD: begin
                    // A response in the timeout cycle takes priority over the abort.
                    if (load_rsp_valid_in) begin
                        state           <= WRITE;
                        instr_ready_out <= 1'b1;
                        rd_addr_out     <= cap_rd;
                        rd_out          <= load_data;
                        wr_en_out       <= cap_wr;
                        retire_out      <= 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        state           <= WRITE;
                        instr_ready_out <= 1'b1;
                        rd_addr_out     <= cap_rd;
                        load_err_out    <= 1'b1;
                        retire_out      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state           <= IDLE;
                    instr_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage against a transaction-level model.
module tb_wb_stage;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        instr_valid_in = 1'b0;
    logic        instr_ready_out;
    logic [4:0]  rd_addr_in = '0;
    logic        rd_wr_en_in = 1'b0;
    logic [1:0]  wb_src_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] pc_plus4_in = '0;
    logic [31:0] csr_data_in = '0;
    logic [2:0]  load_funct3_in = '0;
    logic [1:0]  load_addr_lsb_in = '0;
    logic        load_rsp_valid_in = 1'b0;
    logic [31:0] load_rsp_data_in = '0;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic [31:0] rd_out;
    logic        retire_out;
    logic        load_err_out;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage #(.REG_ADDR_W(5), .LOAD_TIMEOUT(16)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .rd_addr_in(rd_addr_in), .rd_wr_en_in(rd_wr_en_in), .wb_src_in(wb_src_in),
        .alu_result_in(alu_result_in), .pc_plus4_in(pc_plus4_in), .csr_data_in(csr_data_in),
        .load_funct3_in(load_funct3_in), .load_addr_lsb_in(load_addr_lsb_in),
        .load_rsp_valid_in(load_rsp_valid_in), .load_rsp_data_in(load_rsp_data_in),
        .rd_addr_out(rd_addr_out), .wr_en_out(wr_en_out), .rd_out(rd_out),
        .retire_out(retire_out), .load_err_out(load_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: a load is rejected for reserved funct3 or an address not a multiple of its size.
    function automatic bit ref_load_err(input logic [2:0] f3, input logic [1:0] lsb);
        int bytes;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        bytes = 1 << f3[1:0];
        return (int'(lsb) % bytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load_val(input logic [2:0] f3, input logic [1:0] lsb,
                                                 input logic [31:0] word);
        int     bytes;
        longint full;
        longint v;
        bytes = 1 << f3[1:0];
        full  = longint'(1) << (8 * bytes);
        v     = longint'(word >> (8 * int'(lsb))) % full;
        if (!f3[2] && bytes < 4 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic chk_quiet(input string tag, input logic exp_ready);
        chk({tag, "_retire"}, {31'd0, retire_out}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en_out}, 32'd0);
        chk({tag, "_ready"}, {31'd0, instr_ready_out}, {31'd0, exp_ready});
    endtask

    task automatic chk_write(input string tag, input bit exp_wr, input logic [4:0] exp_rd,
                             input logic [31:0] exp_val, input bit exp_err);
        chk({tag, "_retire"}, {31'd0, retire_out}, 32'd1);
        chk({tag, "_wr_en"}, {31'd0, wr_en_out}, {31'd0, exp_wr});
        chk({tag, "_err"}, {31'd0, load_err_out}, {31'd0, exp_err});
        chk({tag, "_rd_addr"}, {27'd0, rd_addr_out}, {27'd0, exp_rd});
        chk({tag, "_ready"}, {31'd0, instr_ready_out}, 32'd1);
        if (exp_wr) chk({tag, "_rd_out"}, rd_out, exp_val);
    endtask

    // Presents one instruction at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic wr,
                         input logic [31:0] val, input logic [2:0] f3, input logic [1:0] lsb);
        wb_src_in        = src;
        rd_addr_in       = rd;
        rd_wr_en_in      = wr;
        alu_result_in    = (src == 2'b00) ? val : $urandom;
        pc_plus4_in      = (src == 2'b10) ? val : $urandom;
        csr_data_in      = (src == 2'b11) ? val : $urandom;
        load_funct3_in   = f3;
        load_addr_lsb_in = lsb;
        instr_valid_in   = 1'b1;
        chk("ready_at_issue", {31'd0, instr_ready_out}, 32'd1);
        tick();
        instr_valid_in = 1'b0;
    endtask

    // Waits d cycles in WAIT_LOAD (offering ignored junk instructions), then returns the response.
    task automatic respond(input int d, input logic [31:0] word);
        for (int i = 0; i < d; i++) begin
            chk_quiet("wait", 1'b0);
            instr_valid_in = $urandom_range(0, 1);
            rd_addr_in     = $urandom;
            wb_src_in      = $urandom;
            tick();
        end
        instr_valid_in    = 1'b0;
        load_rsp_valid_in = 1'b1;
        load_rsp_data_in  = word;
        tick();
        load_rsp_valid_in = 1'b0;
        load_rsp_data_in  = $urandom;
    endtask

    initial begin
        logic [1:0]  src;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic [31:0] word;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        int          d;

        @(negedge clk_in);
        chk_quiet("reset", 1'b1);
        chk("reset_err", {31'd0, load_err_out}, 32'd0);
        chk("reset_rd_out", rd_out, 32'd0);
        chk("reset_rd_addr", {27'd0, rd_addr_out}, 32'd0);
        tick();
        reset_in = 1'b0;
        tick();
        tick();

        issue(2'b00, 5'd5, 1'b1, 32'h1234, 3'd0, 2'd0);
        chk_write("t1_alu", 1'b1, 5'd5, 32'h1234, 1'b0);
        tick();

        issue(2'b01, 5'd7, 1'b1, 32'd0, 3'b000, 2'd2);
        respond(3, 32'h0080_0000);
        chk_write("t2_lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        tick();

        issue(2'b01, 5'd9, 1'b1, 32'd0, 3'b101, 2'd2);
        respond(1, 32'h8001_0000);
        chk_write("t3_lhu", 1'b1, 5'd9, 32'h0000_8001, 1'b0);
        issue(2'b01, 5'd10, 1'b1, 32'd0, 3'b001, 2'd1);
        chk_write("t3_lh_misal", 1'b0, 5'd10, 32'd0, 1'b1);
        tick();

        issue(2'b10, 5'd0, 1'b1, 32'h100, 3'd0, 2'd0);
        chk_write("t4_jal_x0", 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            issue(2'b00, 5'(i), 1'b1, 32'hA0 + 32'(i), 3'd0, 2'd0);
            chk_write("t4_b2b", 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0);
        end
        tick();
        chk_quiet("t4_idle", 1'b1);

        issue(2'b01, 5'd12, 1'b1, 32'd0, 3'b010, 2'd0);
        tick();
        reset_in = 1'b1;
        #1;
        chk_quiet("t5_in_reset", 1'b1);
        @(negedge clk_in);
        reset_in          = 1'b0;
        load_rsp_valid_in = 1'b1;
        load_rsp_data_in  = 32'hDEAD_BEEF;
        tick();
        load_rsp_valid_in = 1'b0;
        chk_quiet("t5_stale_rsp", 1'b1);
        tick();
        chk_quiet("t5_idle", 1'b1);

`ifdef WB_LOAD_TIMEOUT_EN
        issue(2'b01, 5'd13, 1'b1, 32'd0, 3'b010, 2'd0);
        for (int i = 0; i < 16; i++) begin
            chk_quiet("t6_wait", 1'b0);
            tick();
        end
        chk_write("t6_timeout", 1'b0, 5'd13, 32'd0, 1'b1);
        tick();
        issue(2'b01, 5'd14, 1'b1, 32'd0, 3'b010, 2'd0);
        respond(15, 32'h1357_9BDF);
        chk_write("t6_rsp_at_limit", 1'b1, 5'd14, 32'h1357_9BDF, 1'b0);
        tick();
`else
        issue(2'b01, 5'd13, 1'b1, 32'd0, 3'b010, 2'd0);
        respond(20, 32'h1357_9BDF);
        chk_write("t6_long_wait", 1'b1, 5'd13, 32'h1357_9BDF, 1'b0);
        tick();
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(1, 3);
                for (int i = 0; i < d; i++) begin
                    instr_valid_in    = 1'b0;
                    load_rsp_valid_in = $urandom_range(0, 1);
                    load_rsp_data_in  = $urandom;
                    tick();
                    load_rsp_valid_in = 1'b0;
                    chk_quiet("rnd_gap", 1'b1);
                end
            end
            src  = $urandom;
            rd   = $urandom;
            wr   = ($urandom_range(0, 3) != 0);
            val  = $urandom;
            f3   = $urandom;
            lsb  = $urandom;
            word = $urandom;
            issue(src, rd, wr, val, f3, lsb);
            if (src != 2'b01) begin
                chk_write("rnd_reg", wr && rd != 0, rd, val, 1'b0);
            end else if (ref_load_err(f3, lsb)) begin
                chk_write("rnd_load_err", 1'b0, rd, 32'd0, 1'b1);
            end else begin
                respond($urandom_range(0, 5), word);
                chk_write("rnd_load", wr && rd != 0, rd, ref_load_val(f3, lsb, word), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
